// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the FIFO control slice.
//   DEF_DEPTH     - default number of RAM entries (power of 2, >= 4)
//   DEF_AF_MARGIN - almost_full fires this many entries below DEPTH
//   DEF_AE_LEVEL  - default almost_empty threshold (entries)
package fifo_pkg;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_LEVEL  = 2;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: WIDTH-bit wrapping pointer counter.
//   clk - clock, all state on posedge
//   rst - synchronous active-high reset (ptr -> 0)
//   clr - synchronous clear (ptr -> 0), wins over inc
//   inc - advance ptr by one, wrapping mod 2^WIDTH
//   ptr - current counter value
module fifo_ptr_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ptr = cnt_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for an external single-clock FIFO RAM.
//   clk, rst        - clock, synchronous active-high reset
//   flush           - discard all contents (pointers -> 0)
//   clr_err         - clear sticky overflow/underflow
//   w_en, r_en      - write / read requests
//   w_ptr, r_ptr    - RAM write / read indices
//   full, empty     - occupancy flags (combinational from registered pointers)
//   almost_full     - count >= AF_LEVEL
//   almost_empty    - count <= AE_LEVEL
//   count           - occupancy 0..DEPTH
//   rd_valid        - RAM data_out valid (accepted read delayed one cycle)
//   overflow        - sticky: write attempted while full
//   underflow       - sticky: read attempted while empty
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL  = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 clr_err,
  input  logic                 w_en,
  input  logic                 r_en,
  output logic [PTR_WIDTH-1:0] w_ptr,
  output logic [PTR_WIDTH-1:0] r_ptr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 rd_valid,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] AF_THR = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR = CW'(AE_LEVEL);

  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;

  logic rd_valid_q, rd_valid_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Extra MSB on each pointer separates full (lap apart) from empty (same lap).
  fifo_ptr_cnt #(.WIDTH(CW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_acc),
    .ptr (wptr)
  );

  fifo_ptr_cnt #(.WIDTH(CW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_acc),
    .ptr (rptr)
  );

  always_comb begin
    empty        = (wptr == rptr);
    full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                   (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
    count        = wptr - rptr;
    almost_full  = (count >= AF_THR);
    almost_empty = (count <= AE_THR);
    w_ptr        = wptr[PTR_WIDTH-1:0];
    r_ptr        = rptr[PTR_WIDTH-1:0];
  end

  always_comb begin
    wr_acc      = w_en && !full && !flush;
    rd_acc      = r_en && !empty && !flush;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    // A set event in the same cycle takes precedence over clr_err.
    if (w_en && full && !flush) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
    if (r_en && empty && !flush) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic       clk = 1'b0;
  logic       rst, flush, clr_err, w_en, r_en;
  logic [2:0] w_ptr, r_ptr;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       rd_valid, overflow, underflow;

  fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .clr_err      (clr_err),
    .w_en         (w_en),
    .r_en         (r_en),
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .rd_valid     (rd_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; int wp; int rp; int full; int empty;
    int af; int ae; int rdv; int ovf; int unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: occupancy plus running totals of accepted writes/reads.
  int m_cnt = 0, m_wr = 0, m_rd = 0;
  int m_rdv = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  // Drive one cycle of inputs, advance the model, push the expected post-edge view.
  task automatic step(input bit i_rst, input bit i_flush, input bit i_clr,
                      input bit i_w, input bit i_r);
    exp_t e;
    int   wacc, racc;
    rst = i_rst; flush = i_flush; clr_err = i_clr; w_en = i_w; r_en = i_r;
    if (i_rst) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_rdv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (i_w && m_cnt == DEPTH && !i_flush) m_ovf = 1;
      else if (i_clr) m_ovf = 0;
      if (i_r && m_cnt == 0 && !i_flush) m_unf = 1;
      else if (i_clr) m_unf = 0;
      if (i_flush) begin
        m_cnt = 0; m_wr = 0; m_rd = 0; m_rdv = 0;
      end else begin
        wacc  = (i_w && m_cnt < DEPTH) ? 1 : 0;
        racc  = (i_r && m_cnt > 0) ? 1 : 0;
        m_cnt = m_cnt + wacc - racc;
        m_wr += wacc;
        m_rd += racc;
        m_rdv = racc;
      end
    end
    e.cnt   = m_cnt;
    e.wp    = m_wr % DEPTH;
    e.rp    = m_rd % DEPTH;
    e.full  = (m_cnt == DEPTH) ? 1 : 0;
    e.empty = (m_cnt == 0) ? 1 : 0;
    e.af    = (m_cnt >= AFL) ? 1 : 0;
    e.ae    = (m_cnt <= AEL) ? 1 : 0;
    e.rdv   = m_rdv;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, one expected snapshot per cycle.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("count",        int'(count),        e.cnt);
        chk("w_ptr",        int'(w_ptr),        e.wp);
        chk("r_ptr",        int'(r_ptr),        e.rp);
        chk("full",         int'(full),         e.full);
        chk("empty",        int'(empty),        e.empty);
        chk("almost_full",  int'(almost_full),  e.af);
        chk("almost_empty", int'(almost_empty), e.ae);
        chk("rd_valid",     int'(rd_valid),     e.rdv);
        chk("overflow",     int'(overflow),     e.ovf);
        chk("underflow",    int'(underflow),    e.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; clr_err = 1'b0; w_en = 1'b0; r_en = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Fill, then one write while full.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
    // Full with both requests: only the read is taken.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    // Drain, read while empty, then clear errors.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Empty with both requests: only the write is taken.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Interleaved writes and reads across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
    end

    // Flush from count 5 with a read pending.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Reset mid-stream with count 4 and a read in flight; errors set first.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Randomized traffic with occasional flush, clr_err and reset.
    for (int i = 0; i < 400; i++) begin
      bit b_rst, b_fl, b_clr, b_w, b_r;
      b_rst = ($urandom_range(0, 99) < 2);
      b_fl  = ($urandom_range(0, 99) < 3);
      b_clr = ($urandom_range(0, 99) < 10);
      b_w   = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
      b_r   = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
      step(b_rst, b_fl, b_clr, b_w, b_r);
    end

    step(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries in the RAM; power of 2, >= 4.
REQ-002 SHALL have parameter PTR_WIDTH, default $clog2(DEPTH), RAM index width.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (entries).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (entries).
REQ-005 SHALL have port clk  in  1  single clock; all state on posedge clk.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port flush  in  1  synchronous discard of all contents.
REQ-008 SHALL have port clr_err  in  1  clears sticky error flags.
REQ-009 SHALL have port w_en  in  1  write request.
REQ-010 SHALL have port r_en  in  1  read request.
REQ-011 SHALL have port w_ptr  out  PTR_WIDTH  RAM write index.
REQ-012 SHALL have port r_ptr  out  PTR_WIDTH  RAM read index.
REQ-013 SHALL have port full  out  1  no free entry; drives the RAM full input.
REQ-014 SHALL have port empty  out  1  no valid entry; drives the RAM empty input.
REQ-015 SHALL have port almost_full  out  1  count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  out  1  count <= AE_LEVEL.
REQ-017 SHALL have port count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-018 SHALL have port rd_valid  out  1  RAM data_out valid this cycle.
REQ-019 SHALL have port overflow  out  1  sticky: write attempted while full.
REQ-020 SHALL have port underflow  out  1  sticky: read attempted while empty.

Function
REQ-021 SHALL keep internal write/read pointers of PTR_WIDTH+1 bits; w_ptr/r_ptr = low PTR_WIDTH bits.
REQ-022 SHALL assert empty when internal pointers are equal; full when MSBs differ and low bits equal.
REQ-023 SHALL derive full, empty, almost_*, count combinationally from registered pointers (zero-cycle flag latency).
REQ-024 SHALL accept a write (wr_acc) iff w_en && !full && !flush; increment write pointer by 1 at that edge, wrapping mod 2*DEPTH.
REQ-025 SHALL accept a read (rd_acc) iff r_en && !empty && !flush; increment read pointer likewise.
REQ-026 SHALL allow simultaneous wr_acc and rd_acc; count unchanged, both pointers advance.
REQ-027 SHALL, when full with w_en && r_en, accept only the read (count DEPTH -> DEPTH-1); when empty with both, accept only the write (0 -> 1).
REQ-028 SHALL compute count = wptr - rptr modulo 2^(PTR_WIDTH+1).
REQ-029 SHALL drive rd_valid = rd_acc registered one cycle (matches RAM one-cycle read latency).
REQ-030 SHALL set overflow on any edge with w_en && full && !flush; underflow on r_en && empty && !flush.
REQ-031 SHALL clear overflow/underflow when clr_err=1; a same-cycle set event wins over clr_err.
REQ-032 SHALL, on flush=1, set both pointers to 0, force rd_valid=0 next cycle, ignore w_en/r_en; error flags unaffected.

Reset
REQ-033 SHALL, on rst=1 at posedge clk, set pointers 0, rd_valid 0, overflow 0, underflow 0; rst has priority over all inputs.
REQ-034 SHALL present after reset: empty=1, full=0, almost_empty=1, almost_full=0, count=0, w_ptr=r_ptr=0.
REQ-035 SHALL discard any in-flight read when rst asserts mid-operation (rd_valid=0 next cycle).

Structure
REQ-036 SHALL place default DEPTH and threshold constants in shared package fifo_pkg.
REQ-037 SHALL implement each pointer as an instance of sub-module fifo_ptr_cnt (PTR_WIDTH+1 wrap counter with inc and clear).
REQ-038 SHALL contain no storage array; data path remains in the existing RAM block.

Verification (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-039 SHALL cover: reset, 8 writes -> count 8, full=1, almost_full=1 from 6th write; 9th write -> overflow=1, w_ptr stays 0.
REQ-040 SHALL cover: from full, w_en=r_en=1 one cycle -> count 7, full=0, r_ptr=1, w_ptr=0; next cycle rd_valid=1.
REQ-041 SHALL cover: from empty, r_en=1 -> underflow=1, rd_valid=0; clr_err=1 -> underflow=0 next cycle.
REQ-042 SHALL cover: 20 writes/reads interleaved -> pointers wrap 7->0, count never exceeds 8, empty=1 at end.
REQ-043 SHALL cover: count 5 with r_en=1, assert flush -> count 0, empty=1, rd_valid=0 next cycle, errors unchanged.
REQ-044 SHALL cover: rst mid-stream with count 4 and r_en=1 -> count 0, rd_valid=0, overflow/underflow 0.
